// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: op bit positions, multiplier FSM states
// and the control half of the EX/MEM slot.
package ex_pkg;

    localparam int OP_W   = 13;
    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_AND = 2;
    localparam int OP_OR  = 3;
    localparam int OP_XOR = 4;
    localparam int OP_SLL = 5;
    localparam int OP_SRL = 6;
    localparam int OP_ADDI = 7;
    localparam int OP_LI  = 8;
    localparam int OP_LW  = 9;
    localparam int OP_SW  = 10;
    localparam int OP_SRA = 11;
    localparam int OP_MUL = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } ex_state_e;

    typedef struct packed {
        logic wb_en;
        logic mem_rd;
        logic mem_wr;
        logic illegal;
    } ex_slot_ctrl_t;

    function automatic logic op_is_onehot(input logic [OP_W-1:0] op);
        return (op != '0) && ((op & (op - OP_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// Radix-2 shift-add multiplier returning the low XLEN bits of an unsigned product.
// One partial product per cycle; o_done marks the final iteration cycle.
module ex_mul_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_start,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_done,
    output logic [XLEN-1:0] o_prod
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(XLEN - 1);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_acc;
    logic [XLEN-1:0]  r_mcand;
    logic [XLEN-1:0]  r_mplier;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
        end else if (i_flush) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
        end else if (r_busy) begin
            // Bits shifted beyond XLEN never reach the low product, so no wide accumulator.
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_done = r_busy && (r_cnt == LAST);
    assign o_prod = r_acc;

endmodule

// File: rtl/ex_stage_pipe.sv
// Execute stage with valid/ready handshake into a single EX/MEM slot and synchronous flush.
// Define EX_MUL_EN to build the iterative multiplier for op 12; otherwise op 12 is illegal.
module ex_stage_pipe
    import ex_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int RF_AW   = 5,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_op,
    input  logic [XLEN-1:0]    in_rs1,
    input  logic [XLEN-1:0]    in_rs2,
    input  logic [XLEN-1:0]    in_imm,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [RF_AW-1:0]   in_rd,
    input  logic               in_flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [RF_AW-1:0]   out_rd,
    output logic [XLEN-1:0]    out_result,
    output logic [XLEN-1:0]    out_addr,
    output logic               out_wb_en,
    output logic               out_mem_rd,
    output logic               out_mem_wr,
    output logic               out_illegal,
    output logic               busy
);

    logic                   w_accept;
    logic                   w_in_idle;
    logic                   w_is_mul;
    logic                   w_done_load;
    logic [XLEN-1:0]        w_res;
    logic [XLEN-1:0]        w_addr;
    logic [XLEN-1:0]        w_mul_prod;
    logic [RF_AW-1:0]       w_mul_rd;
    logic signed [XLEN-1:0] w_rs2_s;
    ex_slot_ctrl_t          w_ctrl;

    logic                   r_vld_p1;
    logic [RF_AW-1:0]       r_rd_p1;
    logic [XLEN-1:0]        r_res_p1;
    logic [XLEN-1:0]        r_addr_p1;
    ex_slot_ctrl_t          r_ctrl_p1;

    assign w_rs2_s  = in_rs2;
    assign in_ready = w_in_idle && (!r_vld_p1 || out_ready) && !in_flush;
    assign w_accept = in_valid && in_ready;

    // Decode and single-cycle compute.
    always_comb begin
        w_res          = '0;
        w_addr         = '0;
        w_ctrl         = '0;
        w_is_mul       = 1'b0;
        w_ctrl.illegal = !op_is_onehot(in_op);
`ifndef EX_MUL_EN
        if (in_op[OP_MUL]) begin
            w_ctrl.illegal = 1'b1;
        end
`endif
        if (!w_ctrl.illegal) begin
            w_ctrl.wb_en = 1'b1;
            if (in_op[OP_ADD])       w_res = in_rs1 + in_rs2;
            else if (in_op[OP_SUB])  w_res = in_rs1 - in_rs2;
            else if (in_op[OP_AND])  w_res = in_rs1 & in_rs2;
            else if (in_op[OP_OR])   w_res = in_rs1 | in_rs2;
            else if (in_op[OP_XOR])  w_res = in_rs1 ^ in_rs2;
            else if (in_op[OP_SLL])  w_res = in_rs2 << in_shamt;
            else if (in_op[OP_SRL])  w_res = in_rs2 >> in_shamt;
            else if (in_op[OP_SRA])  w_res = w_rs2_s >>> in_shamt;
            else if (in_op[OP_ADDI]) w_res = in_rs1 + in_imm;
            else if (in_op[OP_LI])   w_res = in_imm;
            else if (in_op[OP_LW]) begin
                w_addr        = in_rs1;
                w_ctrl.mem_rd = 1'b1;
            end else if (in_op[OP_SW]) begin
                w_addr        = in_rs1;
                w_res         = in_rs2;
                w_ctrl.mem_wr = 1'b1;
                w_ctrl.wb_en  = 1'b0;
            end else begin
                w_is_mul = 1'b1;
            end
        end
    end

`ifdef EX_MUL_EN
    ex_state_e        r_state;
    ex_state_e        w_state_nxt;
    logic             w_mul_start;
    logic             w_mul_done;
    logic [RF_AW-1:0] r_mul_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_mul_rd <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_mul_start) begin
                r_mul_rd <= in_rd;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mul_start = 1'b0;
        w_done_load = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept && w_is_mul) begin
                    w_state_nxt = MUL;
                    w_mul_start = 1'b1;
                end
            end
            MUL: begin
                if (w_mul_done) w_state_nxt = DONE;
            end
            DONE: begin
                if (!r_vld_p1 || out_ready) begin
                    w_done_load = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (in_flush) begin
            w_state_nxt = IDLE;
            w_mul_start = 1'b0;
            w_done_load = 1'b0;
        end
    end

    ex_mul_iter #(
        .XLEN(XLEN)
    ) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_mul_start),
        .i_flush (in_flush),
        .i_a     (in_rs1),
        .i_b     (in_rs2),
        .o_done  (w_mul_done),
        .o_prod  (w_mul_prod)
    );

    assign w_in_idle = (r_state == IDLE);
    assign busy      = (r_state == MUL);
    assign w_mul_rd  = r_mul_rd;
`else
    assign w_in_idle   = 1'b1;
    assign w_done_load = 1'b0;
    assign w_mul_prod  = '0;
    assign w_mul_rd    = '0;
    assign busy        = 1'b0;
`endif

    // EX/MEM slot (stage p1).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1  <= 1'b0;
            r_rd_p1   <= '0;
            r_res_p1  <= '0;
            r_addr_p1 <= '0;
            r_ctrl_p1 <= '0;
        end else if (in_flush) begin
            r_vld_p1  <= 1'b0;
            r_rd_p1   <= '0;
            r_res_p1  <= '0;
            r_addr_p1 <= '0;
            r_ctrl_p1 <= '0;
        end else if (w_accept && !w_is_mul) begin
            r_vld_p1  <= 1'b1;
            r_rd_p1   <= in_rd;
            r_res_p1  <= w_res;
            r_addr_p1 <= w_addr;
            r_ctrl_p1 <= w_ctrl;
        end else if (w_done_load) begin
            r_vld_p1  <= 1'b1;
            r_rd_p1   <= w_mul_rd;
            r_res_p1  <= w_mul_prod;
            r_addr_p1 <= '0;
            r_ctrl_p1 <= '{wb_en: 1'b1, mem_rd: 1'b0, mem_wr: 1'b0, illegal: 1'b0};
        end else if (r_vld_p1 && out_ready) begin
            r_vld_p1 <= 1'b0;
        end
    end

    assign out_valid   = r_vld_p1;
    assign out_rd      = r_rd_p1;
    assign out_result  = r_res_p1;
    assign out_addr    = r_addr_p1;
    assign out_wb_en   = r_ctrl_p1.wb_en;
    assign out_mem_rd  = r_ctrl_p1.mem_rd;
    assign out_mem_wr  = r_ctrl_p1.mem_wr;
    assign out_illegal = r_ctrl_p1.illegal;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Directed bench for ex_stage_pipe: a scoreboard queue holds the expected slot for every
// accepted op and is drained whenever the memory side takes the slot.
module tb_ex_stage_pipe;

    localparam int XLEN    = 32;
    localparam int RF_AW   = 5;
    localparam int SHAMT_W = 5;
    localparam int OP_W    = 13;
`ifdef EX_MUL_EN
    localparam bit MUL_BUILD = 1'b1;
`else
    localparam bit MUL_BUILD = 1'b0;
`endif

    typedef struct packed {
        logic [RF_AW-1:0] rd;
        logic [XLEN-1:0]  res;
        logic [XLEN-1:0]  addr;
        logic             wb;
        logic             mrd;
        logic             mwr;
        logic             ill;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [OP_W-1:0]    in_op = '0;
    logic [XLEN-1:0]    in_rs1 = '0;
    logic [XLEN-1:0]    in_rs2 = '0;
    logic [XLEN-1:0]    in_imm = '0;
    logic [SHAMT_W-1:0] in_shamt = '0;
    logic [RF_AW-1:0]   in_rd = '0;
    logic               in_flush = 1'b0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [RF_AW-1:0]   out_rd;
    logic [XLEN-1:0]    out_result;
    logic [XLEN-1:0]    out_addr;
    logic               out_wb_en;
    logic               out_mem_rd;
    logic               out_mem_wr;
    logic               out_illegal;
    logic               busy;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    ex_stage_pipe #(.XLEN(XLEN), .RF_AW(RF_AW), .SHAMT_W(SHAMT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_shamt(in_shamt), .in_rd(in_rd),
        .in_flush(in_flush), .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_result(out_result), .out_addr(out_addr), .out_wb_en(out_wb_en),
        .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_illegal(out_illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [OP_W-1:0] op, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b, input logic [XLEN-1:0] imm,
                                   input logic [SHAMT_W-1:0] sh, input logic [RF_AW-1:0] rd);
        exp_t e;
        e    = '0;
        e.rd = rd;
        if ($countones(op) != 1 || (op[12] && !MUL_BUILD)) begin
            e.ill = 1'b1;
            return e;
        end
        e.wb = 1'b1;
        case (op)
            13'h0001: e.res = a + b;
            13'h0002: e.res = a - b;
            13'h0004: e.res = a & b;
            13'h0008: e.res = a | b;
            13'h0010: e.res = a ^ b;
            13'h0020: e.res = b << sh;
            13'h0040: e.res = b >> sh;
            13'h0080: e.res = a + imm;
            13'h0100: e.res = imm;
            13'h0200: begin e.addr = a; e.mrd = 1'b1; end
            13'h0400: begin e.addr = a; e.res = b; e.mwr = 1'b1; e.wb = 1'b0; end
            13'h0800: e.res = (b >> sh) | (b[XLEN-1] ? ~({XLEN{1'b1}} >> sh) : '0);
            default:  e.res = a * b;
        endcase
        return e;
    endfunction

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one op, wait (bounded) for acceptance, return 1 time unit after the accepting edge.
    task automatic send(input logic [OP_W-1:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input logic [XLEN-1:0] imm,
                        input logic [SHAMT_W-1:0] sh, input logic [RF_AW-1:0] rd,
                        input bit expect_out);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_rs1   = a;
        in_rs2   = b;
        in_imm   = imm;
        in_shamt = sh;
        in_rd    = rd;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        chk1("accept_ready", in_ready, 1'b1);
        if (expect_out) q.push_back(model(op, a, b, imm, sh, rd));
        step();
        in_valid = 1'b0;
    endtask

    always @(negedge clk) begin : monitor
        exp_t obs;
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            obs = {out_rd, out_result, out_addr, out_wb_en, out_mem_rd, out_mem_wr, out_illegal};
            checks++;
            if (q.size() == 0) begin
                errors++;
                $error("FAIL slot_unexpected observed=%h expected=none", obs);
            end else begin
                e = q.pop_front();
                assert (obs === e) else begin
                    errors++;
                    $error("FAIL slot observed=%h expected=%h", obs, e);
                end
            end
        end
    end

    initial begin
        int k;
        int nbusy;

        // Reset state
        #3;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b1);
        chk("rst_result", out_result, 32'h0);
        chk1("rst_wb_en", out_wb_en, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Single ops with latency check, then a back-to-back burst
        send(13'h0001, 32'hFFFF_FFFF, 32'h1, 32'h0, 5'd0, 5'd3, 1'b1);
        chk1("add_latency", out_valid, 1'b1);
        chk("add_result", out_result, 32'h0);
        send(13'h0800, 32'h0, 32'h8000_0000, 32'h0, 5'd4, 5'd4, 1'b1);
        chk("sra_result", out_result, 32'hF800_0000);
        send(13'h0040, 32'h0, 32'h8000_0000, 32'h0, 5'd4, 5'd5, 1'b1);
        chk("srl_result", out_result, 32'h0800_0000);
        send(13'h0002, 32'h5, 32'h7, 32'h0, 5'd0, 5'd6, 1'b1);
        send(13'h0004, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h0, 5'd0, 5'd7, 1'b1);
        send(13'h0008, 32'hA000_0001, 32'h0500_0010, 32'h0, 5'd0, 5'd8, 1'b1);
        send(13'h0010, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0, 5'd0, 5'd9, 1'b1);
        send(13'h0020, 32'h0, 32'h0000_0003, 32'h0, 5'd31, 5'd10, 1'b1);
        send(13'h0080, 32'h10, 32'h0, 32'hFFFF_FFF0, 5'd0, 5'd11, 1'b1);
        send(13'h0100, 32'h0, 32'h0, 32'h1234_5678, 5'd0, 5'd12, 1'b1);
        send(13'h0200, 32'h0000_0400, 32'h55, 32'h0, 5'd0, 5'd13, 1'b1);
        send(13'h0800, 32'h0, 32'h7000_0000, 32'h0, 5'd31, 5'd14, 1'b1);
        step();
        step();
        chk1("burst_drained", out_valid, 1'b0);

        // SW held by memory back-pressure
        out_ready = 1'b0;
        send(13'h0400, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 5'd0, 5'd1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("sw_hold_valid", out_valid, 1'b1);
            chk1("sw_hold_in_ready", in_ready, 1'b0);
            chk1("sw_hold_mem_wr", out_mem_wr, 1'b1);
            chk("sw_hold_addr", out_addr, 32'h0000_0100);
            chk("sw_hold_result", out_result, 32'hDEAD_BEEF);
        end
        step();
        out_ready = 1'b1;
        step();
        chk1("sw_drained", out_valid, 1'b0);

        // Illegal ops
        send(13'h0003, 32'h1, 32'h2, 32'h0, 5'd0, 5'd2, 1'b1);
        chk1("ill_flag", out_illegal, 1'b1);
        chk1("ill_wb_en", out_wb_en, 1'b0);
        send(13'h0000, 32'h1, 32'h2, 32'h0, 5'd0, 5'd2, 1'b1);
        chk1("ill_zero_flag", out_illegal, 1'b1);
        step();

        // Op 12: multiplier or illegal depending on build
        send(13'h1000, 32'd7, 32'd6, 32'h0, 5'd0, 5'd9, 1'b1);
        k     = 0;
        nbusy = 0;
        while (!out_valid && k < 100) begin
            if (busy) nbusy++;
            if (k == 5) chk1("mul_in_ready_busy", in_ready, 1'b0);
            step();
            k++;
        end
        if (MUL_BUILD) begin
            chk("mul_latency", k, 32'd33);
            chk("mul_busy_cycles", nbusy, 32'd32);
            chk("mul_result", out_result, 32'd42);
        end else begin
            chk("op12_latency", k, 32'd0);
            chk1("op12_illegal", out_illegal, 1'b1);
        end
        step();
        step();

        // Flush of an in-flight op: MUL in the multiplier build, otherwise a stalled ADD
        if (MUL_BUILD) begin
            send(13'h1000, 32'd7, 32'd6, 32'h0, 5'd0, 5'd9, 1'b0);
            repeat (9) step();
        end else begin
            out_ready = 1'b0;
            send(13'h0001, 32'd1, 32'd2, 32'h0, 5'd0, 5'd9, 1'b0);
        end
        in_flush = 1'b1;
        #1;
        chk1("flush_in_ready_low", in_ready, 1'b0);
        step();
        in_flush  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk1("flush_in_ready", in_ready, 1'b1);
        chk1("flush_busy", busy, 1'b0);
        chk1("flush_valid", out_valid, 1'b0);
        chk("flush_result", out_result, 32'h0);
        repeat (40) step();
        chk1("flush_no_result", out_valid, 1'b0);

        // Asynchronous reset while the slot is valid
        out_ready = 1'b0;
        send(13'h0001, 32'h11, 32'h22, 32'h0, 5'd0, 5'd15, 1'b0);
        chk1("pre_rst_valid", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1("async_rst_valid", out_valid, 1'b0);
        chk("async_rst_result", out_result, 32'h0);
        chk("async_rst_rd", 32'(out_rd), 32'h0);
        chk1("async_rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        chk1("post_rst_in_ready", in_ready, 1'b1);
        send(13'h0100, 32'h0, 32'h0, 32'hCAFE_F00D, 5'd0, 5'd1, 1'b1);
        step();
        step();

        chk("scoreboard_empty", q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
